// File: rtl/dbg_stream_pkg.sv
// Shared types for the debug frame streamer: frame FSM states, the captured
// snapshot layout and the frame payload size.
package dbg_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    DATA,
    CHK
  } dbg_state_e;

  typedef struct packed {
    logic [7:0]  seq;
    logic [31:0] w3;
    logic [31:0] w2;
    logic [31:0] w1;
  } dbg_snap_t;

  localparam int FRAME_DATA_BYTES = 12;

endpackage

// File: rtl/debug_frame_streamer_if.sv
// Valid/ready byte stream from the debug frame streamer to the UART/JTAG bridge.
interface debug_frame_streamer_if;

  logic [7:0] byte_o;
  logic       byte_vld_o;
  logic       byte_rdy_i;

  modport master (output byte_o, output byte_vld_o, input byte_rdy_i);
  modport slave  (input byte_o, input byte_vld_o, output byte_rdy_i);

endinterface

// File: rtl/dbg_snap_fifo.sv
// Synchronous snapshot FIFO with show-ahead read; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module dbg_snap_fifo
  import dbg_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  dbg_snap_t                din,
  input  logic                     pop,
  output dbg_snap_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  dbg_snap_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           push_ok;
  logic           pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/debug_frame_streamer.sv
// Captures debug snapshots on trigger and streams each as a SYNC/SEQ/12-byte
// frame; defining DBG_STREAM_CHKSUM_EN appends an XOR checksum byte.
module debug_frame_streamer
  import dbg_stream_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   debug_1_i,
  input  logic [31:0]                   debug_2_i,
  input  logic [31:0]                   debug_3_i,
  input  logic                          trig_i,
  debug_frame_streamer_if.master        stream,
  output logic                          busy_o,
  output logic [7:0]                    drop_cnt_o,
  output logic                          ovf_o
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_DATA_BYTES - 1);

  dbg_state_e  state_reg;
  dbg_snap_t   frame_reg;
  logic [7:0]  byte_reg;
  logic        byte_vld_reg;
  logic [3:0]  idx_reg;
  logic [7:0]  seq_reg;
  logic [7:0]  drop_cnt_reg;
  logic        ovf_reg;
`ifdef DBG_STREAM_CHKSUM_EN
  logic [7:0]  chk_reg;
`endif

  dbg_snap_t                    fifo_din;
  dbg_snap_t                    fifo_dout;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_pop;
  logic                         push_ok;
  logic                         hs;
  logic [95:0]                  frame_data;
  logic [7:0]                   data_bytes [16];
  logic [7:0]                   next_data_byte;

  assign fifo_pop = (state_reg == IDLE) && !fifo_empty;
  assign push_ok  = trig_i && (!fifo_full || fifo_pop);
  assign fifo_din = '{seq: seq_reg, w3: debug_3_i, w2: debug_2_i, w1: debug_1_i};
  assign hs       = byte_vld_reg && stream.byte_rdy_i;

  dbg_snap_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Payload bytes word 1..3, LSB first; padded to 16 so the 4-bit index never runs off.
  assign frame_data = {frame_reg.w3, frame_reg.w2, frame_reg.w1};
  for (genvar gi = 0; gi < 16; gi++) begin : g_data_byte
    if (gi < FRAME_DATA_BYTES) begin : g_byte
      assign data_bytes[gi] = frame_data[gi*8 +: 8];
    end else begin : g_pad
      assign data_bytes[gi] = '0;
    end
  end
  assign next_data_byte = data_bytes[idx_reg + 4'd1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      frame_reg    <= '0;
      byte_reg     <= '0;
      byte_vld_reg <= 1'b0;
      idx_reg      <= '0;
      seq_reg      <= '0;
      drop_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
`ifdef DBG_STREAM_CHKSUM_EN
      chk_reg      <= '0;
`endif
    end else begin
      if (push_ok) begin
        seq_reg <= seq_reg + 8'd1;
      end
      if (trig_i && !push_ok) begin
        ovf_reg <= 1'b1;
        if (drop_cnt_reg != 8'hFF) begin
          drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
      end

      // Each branch loads the byte for the next state so it appears right after the handshake.
      case (state_reg)
        IDLE: begin
          if (fifo_pop) begin
            frame_reg    <= fifo_dout;
            byte_reg     <= SYNC_BYTE;
            byte_vld_reg <= 1'b1;
            state_reg    <= SYNC;
          end
        end
        SYNC: begin
          if (hs) begin
            byte_reg  <= frame_reg.seq;
            state_reg <= SEQ;
`ifdef DBG_STREAM_CHKSUM_EN
            chk_reg   <= frame_reg.seq;
`endif
          end
        end
        SEQ: begin
          if (hs) begin
            byte_reg  <= data_bytes[0];
            idx_reg   <= '0;
            state_reg <= DATA;
`ifdef DBG_STREAM_CHKSUM_EN
            chk_reg   <= chk_reg ^ data_bytes[0];
`endif
          end
        end
        DATA: begin
          if (hs) begin
            if (idx_reg == LAST_IDX) begin
`ifdef DBG_STREAM_CHKSUM_EN
              byte_reg     <= chk_reg;
              state_reg    <= CHK;
`else
              byte_reg     <= '0;
              byte_vld_reg <= 1'b0;
              state_reg    <= IDLE;
`endif
            end else begin
              idx_reg  <= idx_reg + 4'd1;
              byte_reg <= next_data_byte;
`ifdef DBG_STREAM_CHKSUM_EN
              chk_reg  <= chk_reg ^ next_data_byte;
`endif
            end
          end
        end
`ifdef DBG_STREAM_CHKSUM_EN
        CHK: begin
          if (hs) begin
            byte_reg     <= '0;
            byte_vld_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
`endif
        default: begin
          byte_reg     <= '0;
          byte_vld_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign stream.byte_o     = byte_reg;
  assign stream.byte_vld_o = byte_vld_reg;
  assign busy_o            = (state_reg != IDLE) || (fifo_count != '0);
  assign drop_cnt_o        = drop_cnt_reg;
  assign ovf_o             = ovf_reg;

endmodule
